// File: rtl/sys_arr_pkg.sv
// Shared types and constants for the systolic-array datapath.
// Holds the psum lane width, the vector register count, and the lane and
// writeback-destination typedefs used by the writeback path.
package sys_arr_pkg;

  localparam int unsigned LANE_W     = 16;
  localparam int unsigned VEGGIEREGS = 256;
  localparam int unsigned ENTRY_BITS = $clog2(VEGGIEREGS);

  typedef logic [LANE_W-1:0]     lane_t;
  typedef logic [ENTRY_BITS-1:0] wbdst_t;

endpackage

// File: rtl/gsau_wb_fifo.sv
// In-order storage FIFO for buffered writeback rows.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; clears pointers and count
//   push_i   write wdata_i at the tail (ignored when full)
//   pop_i    drop the head entry (ignored when empty)
//   wdata_i  entry to push
//   rdata_o  head entry
//   full_o   DEPTH entries held
//   empty_o  no entries held
//   count_o  number of entries held
module gsau_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gsau_wb_serializer.sv
// Writeback serializer: buffers psum rows from the GSAU control unit and
// writes each row into the vector register file as BEATS slices.
// Optional feature macro: GSAU_WB_PERF_EN adds perf_rows / perf_stall.
// Ports:
//   CLK, RST              clock; synchronous active-high reset
//   in_valid/in_ready     row handshake (push when both high)
//   in_wbdst, in_psum     destination register and psum row (lane 0 in LSBs)
//   rf_wr_req/rf_wr_gnt   register-file write port request / grant per beat
//   rf_wr_addr/beat/data  destination, beat index, beat data slice
//   rf_wr_last            current beat is the final beat of the row
//   busy                  entry buffered or write in progress
//   perf_rows/perf_stall  (macro only) saturating completed-row / stall counters
module gsau_wb_serializer
  import sys_arr_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LANE_W     = sys_arr_pkg::LANE_W,
  parameter int unsigned BEATS      = 2,
  parameter int unsigned VEGGIEREGS = sys_arr_pkg::VEGGIEREGS,
  localparam int unsigned ENTRY_BITS = $clog2(VEGGIEREGS),
  localparam int unsigned ROW_W      = LANES * LANE_W,
  localparam int unsigned BEAT_DW    = ROW_W / BEATS,
  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ENTRY_BITS-1:0] in_wbdst,
  input  logic [ROW_W-1:0]      in_psum,
  output logic                  rf_wr_req,
  input  logic                  rf_wr_gnt,
  output logic [ENTRY_BITS-1:0] rf_wr_addr,
  output logic [BEAT_W-1:0]     rf_wr_beat,
  output logic [BEAT_DW-1:0]    rf_wr_data,
  output logic                  rf_wr_last,
`ifdef GSAU_WB_PERF_EN
  output logic [31:0]           perf_rows,
  output logic [31:0]           perf_stall,
`endif
  output logic                  busy
);

  localparam int unsigned ENT_W = ENTRY_BITS + ROW_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {StIdle, StWrite} state_e;

  state_e                          state_q, state_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic                            fifo_full, fifo_empty;
  logic [CNT_W-1:0]                fifo_count;
  logic [ENT_W-1:0]                head;
  logic [ENTRY_BITS-1:0]           head_wbdst;
  logic [BEATS-1:0][BEAT_DW-1:0]   head_beats;
  logic                            push, pop, grant, last_beat, active;

  assign in_ready = !fifo_full && !RST;
  assign push     = in_valid && in_ready;
  assign active   = (state_q == StWrite) && !RST;
  assign grant    = active && rf_wr_gnt;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign pop      = grant && last_beat;

  gsau_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_wbdst, in_psum}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_wbdst = head[ENT_W-1 -: ENTRY_BITS];
  assign head_beats = head[ROW_W-1:0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty || push) state_d = StWrite;
      end
      StWrite: begin
        if (grant) begin
          if (last_beat) begin
            beat_d = '0;
            // Stay busy if anything besides the popped head remains.
            if (fifo_count > CNT_W'(1) || push) state_d = StWrite;
            else                                state_d = StIdle;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs are zeroed whenever no request is active, which also covers reset.
  assign rf_wr_req  = active;
  assign rf_wr_addr = active ? head_wbdst : '0;
  assign rf_wr_beat = active ? beat_q : '0;
  assign rf_wr_data = active ? head_beats[beat_q] : '0;
  assign rf_wr_last = active && last_beat;
  assign busy       = !RST && ((state_q == StWrite) || !fifo_empty);

`ifdef GSAU_WB_PERF_EN
  logic [31:0] perf_rows_q, perf_stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_rows_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop && perf_rows_q != '1) perf_rows_q <= perf_rows_q + 32'd1;
      if (active && !rf_wr_gnt && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_rows  = perf_rows_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_gsau_wb_serializer.sv
// Directed self-checking bench for gsau_wb_serializer (default parameters).
module tb_gsau_wb_serializer;
  import sys_arr_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_wbdst = '0;
  logic [63:0] in_psum = '0;
  logic        rf_wr_req;
  logic        rf_wr_gnt = 1'b0;
  logic [7:0]  rf_wr_addr;
  logic [0:0]  rf_wr_beat;
  logic [31:0] rf_wr_data;
  logic        rf_wr_last;
  logic        busy;
`ifdef GSAU_WB_PERF_EN
  logic [31:0] perf_rows, perf_stall;
`endif

  int tests = 0;
  int fails = 0;

  gsau_wb_serializer dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wbdst   (in_wbdst),
    .in_psum    (in_psum),
    .rf_wr_req  (rf_wr_req),
    .rf_wr_gnt  (rf_wr_gnt),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_beat (rf_wr_beat),
    .rf_wr_data (rf_wr_data),
    .rf_wr_last (rf_wr_last),
`ifdef GSAU_WB_PERF_EN
    .perf_rows  (perf_rows),
    .perf_stall (perf_stall),
`endif
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    rf_wr_gnt = 1'b0;
    step();
    step();
    RST = 1'b0;
    #1;
  endtask

  // Row with lanes base, base+1, base+2, base+3 (lane 0 in LSBs).
  function automatic logic [63:0] row_psum(int base);
    lane_t l0, l1, l2, l3;
    l0 = lane_t'(base);
    l1 = lane_t'(base + 1);
    l2 = lane_t'(base + 2);
    l3 = lane_t'(base + 3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    in_valid = 1'b1;
    in_wbdst = 8'hAA;
    in_psum = row_psum(100);
    rf_wr_gnt = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    tests++; if (rf_wr_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", rf_wr_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if ({rf_wr_addr, rf_wr_beat, rf_wr_data, rf_wr_last} !== 42'd0) begin
      fails++; $display("FAIL rst_outs got=%h/%h/%h/%b exp=0", rf_wr_addr, rf_wr_beat, rf_wr_data, rf_wr_last);
    end
    step();
    tests++; if (rf_wr_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_hold req=%b busy=%b exp=0/0", rf_wr_req, busy);
    end
    RST = 1'b0;
    in_valid = 1'b0;
    rf_wr_gnt = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
    step();
    tests++; if (rf_wr_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_push_ignored req=%b busy=%b exp=0/0", rf_wr_req, busy);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_wbdst = 8'h05;
    in_psum = 64'h0004_0003_0002_0001;
    rf_wr_gnt = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (rf_wr_req !== 1'b1 || rf_wr_addr !== 8'h05 || rf_wr_beat !== 1'b0) begin
      fails++; $display("FAIL single_b0_ctl req=%b addr=%h beat=%h exp=1/05/0", rf_wr_req, rf_wr_addr, rf_wr_beat);
    end
    tests++; if (rf_wr_data !== 32'h0002_0001 || rf_wr_last !== 1'b0) begin
      fails++; $display("FAIL single_b0_data got=%h last=%b exp=00020001/0", rf_wr_data, rf_wr_last);
    end
    step();
    tests++; if (rf_wr_req !== 1'b1 || rf_wr_beat !== 1'b1 || rf_wr_last !== 1'b1) begin
      fails++; $display("FAIL single_b1_ctl req=%b beat=%h last=%b exp=1/1/1", rf_wr_req, rf_wr_beat, rf_wr_last);
    end
    tests++; if (rf_wr_data !== 32'h0004_0003) begin
      fails++; $display("FAIL single_b1_data got=%h exp=00040003", rf_wr_data);
    end
    step();
    tests++; if (rf_wr_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_done req=%b busy=%b exp=0/0", rf_wr_req, busy);
    end
`ifdef GSAU_WB_PERF_EN
    tests++; if (perf_rows !== 32'd1) begin fails++; $display("FAIL single_perf_rows got=%0d exp=1", perf_rows); end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    rf_wr_gnt = 1'b0;
    in_valid = 1'b1;
    in_wbdst = 8'h07;
    in_psum = row_psum(8);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (rf_wr_req !== 1'b1 || rf_wr_addr !== 8'h07 || rf_wr_beat !== 1'b0 ||
                   rf_wr_data !== 32'h0009_0008 || rf_wr_last !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d] req=%b addr=%h beat=%h data=%h last=%b exp=1/07/0/00090008/0",
                          i, rf_wr_req, rf_wr_addr, rf_wr_beat, rf_wr_data, rf_wr_last);
      end
      if (i != 3) step();
    end
`ifdef GSAU_WB_PERF_EN
    tests++; if (perf_stall !== 32'd3) begin fails++; $display("FAIL stall_perf got=%0d exp=3", perf_stall); end
`endif
    rf_wr_gnt = 1'b1;
    step();
    tests++; if (rf_wr_data !== 32'h000b_000a || rf_wr_last !== 1'b1) begin
      fails++; $display("FAIL stall_b1 data=%h last=%b exp=000b000a/1", rf_wr_data, rf_wr_last);
    end
    step();
    tests++; if (rf_wr_req !== 1'b0) begin fails++; $display("FAIL stall_done req=%b exp=0", rf_wr_req); end
`ifdef GSAU_WB_PERF_EN
    tests++; if (perf_stall !== 32'd3 || perf_rows !== 32'd1) begin
      fails++; $display("FAIL stall_perf_end stall=%0d rows=%0d exp=3/1", perf_stall, perf_rows);
    end
`endif
  endtask

  task automatic test_fill();
    lane_t lo, hi;
    do_reset();
    rf_wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_wbdst = 8'(i);
      in_psum = row_psum(4 * i);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_full got=%b exp=0", in_ready); end
    in_valid = 1'b1;
    in_wbdst = 8'h09;
    in_psum = '0;
    step();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_still_full got=%b exp=0", in_ready); end
    rf_wr_gnt = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      lo = lane_t'(4 * (k / 2) + 2 * (k % 2));
      hi = lane_t'(4 * (k / 2) + 2 * (k % 2) + 1);
      tests++; if (rf_wr_req !== 1'b1 || rf_wr_addr !== 8'(k / 2) || rf_wr_beat !== 1'(k % 2) ||
                   rf_wr_data !== {hi, lo}) begin
        fails++; $display("FAIL fill_drain[%0d] req=%b addr=%h beat=%h data=%h exp=1/%h/%0d/%h",
                          k, rf_wr_req, rf_wr_addr, rf_wr_beat, rf_wr_data, 8'(k / 2), k % 2, {hi, lo});
      end
      step();
    end
    tests++; if (rf_wr_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL fill_done req=%b busy=%b exp=0/0", rf_wr_req, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rf_wr_gnt = 1'b1;
    in_valid = 1'b1;
    in_wbdst = 8'h10;
    in_psum = row_psum(16);
    step();
    in_valid = 1'b0;
    tests++; if (rf_wr_addr !== 8'h10 || rf_wr_beat !== 1'b0) begin
      fails++; $display("FAIL b2b_first addr=%h beat=%h exp=10/0", rf_wr_addr, rf_wr_beat);
    end
    step();
    tests++; if (rf_wr_last !== 1'b1 || rf_wr_addr !== 8'h10) begin
      fails++; $display("FAIL b2b_first_last last=%b addr=%h exp=1/10", rf_wr_last, rf_wr_addr);
    end
    in_valid = 1'b1;
    in_wbdst = 8'h11;
    in_psum = row_psum(20);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (rf_wr_req !== 1'b1 || rf_wr_addr !== 8'h11 || rf_wr_beat !== 1'b0 ||
                 rf_wr_data !== 32'h0015_0014) begin
      fails++; $display("FAIL b2b_second req=%b addr=%h beat=%h data=%h exp=1/11/0/00150014",
                        rf_wr_req, rf_wr_addr, rf_wr_beat, rf_wr_data);
    end
    step();
    tests++; if (rf_wr_last !== 1'b1 || rf_wr_data !== 32'h0017_0016) begin
      fails++; $display("FAIL b2b_second_b1 last=%b data=%h exp=1/00170016", rf_wr_last, rf_wr_data);
    end
    step();
    tests++; if (rf_wr_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_done req=%b busy=%b exp=0/0", rf_wr_req, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf_wr_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_wbdst = 8'(8'h20 + i);
      in_psum = row_psum(40 + 4 * i);
      step();
    end
    in_valid = 1'b0;
    rf_wr_gnt = 1'b1;
    step();
    rf_wr_gnt = 1'b0;
    tests++; if (rf_wr_beat !== 1'b1 || rf_wr_addr !== 8'h20) begin
      fails++; $display("FAIL mid_pre beat=%h addr=%h exp=1/20", rf_wr_beat, rf_wr_addr);
    end
    RST = 1'b1;
    step();
    tests++; if (rf_wr_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL mid_rst req=%b busy=%b ready=%b exp=0/0/0", rf_wr_req, busy, in_ready);
    end
    RST = 1'b0;
    rf_wr_gnt = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rel_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (rf_wr_req !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL mid_stale[%0d] req=%b busy=%b exp=0/0", i, rf_wr_req, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
